// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice datapath.
// Holds the ADSR state encoding and the envelope level limits.
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } env_state_t;

    localparam logic [7:0] ENV_MAX = 8'd255;
    localparam logic [7:0] ENV_MIN = 8'd0;

endpackage

// File: rtl/adsr_envelope_prescaler.sv
// Step-rate prescaler for the ADSR envelope: pulses tick once every div cycles
// while run is high; clear restarts the count so the first tick lands div cycles later.
module env_prescaler (
    input  logic        clk,
    input  logic        nRst,
    input  logic        clear,
    input  logic        run,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] count;

    assign tick = run && (count == (div - 16'd1));

    // NOTE: reset is synchronous here, so nRst sits inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (!nRst || clear) begin
            count <= 16'd0;
        end else if (run) begin
            count <= tick ? 16'd0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR amplitude envelope applied to the oscillator sample.
// Define ENV_RETRIG_EN to restart from level 0 on every gate rising edge; default is legato.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter logic [15:0] ATTACK_DIV  = 16'd64,
    parameter logic [15:0] DECAY_DIV   = 16'd128,
    parameter logic [15:0] RELEASE_DIV = 16'd256,
    parameter logic [7:0]  SUSTAIN_LVL = 8'd192
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       gate,
    input  logic [7:0] sample_in,
    output logic [7:0] sample_out,
    output logic [7:0] env_level,
    output env_state_t env_state,
    output logic       active
);

    env_state_t  state_next;
    logic [7:0]  level_next;
    logic [7:0]  level_dec;
    logic [15:0] div_sel;
    logic [15:0] product;
    logic        run;
    logic        tick;
    logic        retrig;
    logic        clear;

    assign run       = (env_state == ATTACK) || (env_state == DECAY) || (env_state == RELEASE);
    assign clear     = (state_next != env_state) || retrig;
    assign level_dec = env_level - 8'd1;
    assign active    = (env_state != IDLE);

    always_comb begin
        case (env_state)
            ATTACK:  div_sel = ATTACK_DIV;
            DECAY:   div_sel = DECAY_DIV;
            default: div_sel = RELEASE_DIV;
        endcase
    end

    env_prescaler u_prescaler (
        .clk   (clk),
        .nRst  (nRst),
        .clear (clear),
        .run   (run),
        .div   (div_sel),
        .tick  (tick)
    );

`ifdef ENV_RETRIG_EN
    logic gate_q;

    always_ff @(posedge clk) begin
        if (!nRst) gate_q <= 1'b0;
        else       gate_q <= gate;
    end
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = env_state;
        level_next = env_level;
        retrig     = 1'b0;
        // Gate changes win over a level step landing in the same cycle.
        case (env_state)
            IDLE: begin
                if (gate) state_next = ATTACK;
            end
            ATTACK: begin
                if (!gate) begin
                    state_next = RELEASE;
                end else if (env_level == ENV_MAX) begin
                    state_next = DECAY;
                end else if (tick) begin
                    level_next = env_level + 8'd1;
                    if (env_level == ENV_MAX - 8'd1) state_next = DECAY;
                end
            end
            DECAY: begin
                if (!gate) begin
                    state_next = RELEASE;
                end else if (env_level <= SUSTAIN_LVL) begin
                    state_next = SUSTAIN;
                    level_next = SUSTAIN_LVL;
                end else if (tick) begin
                    level_next = level_dec;
                    if (level_dec == SUSTAIN_LVL) state_next = SUSTAIN;
                end
            end
            SUSTAIN: begin
                level_next = SUSTAIN_LVL;
                if (!gate) state_next = RELEASE;
            end
            RELEASE: begin
                if (gate) begin
                    state_next = ATTACK;
                end else if (env_level == ENV_MIN) begin
                    state_next = IDLE;
                end else if (tick) begin
                    level_next = level_dec;
                    if (level_dec == ENV_MIN) state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                level_next = ENV_MIN;
            end
        endcase
`ifdef ENV_RETRIG_EN
        if (gate && !gate_q && env_state != IDLE) begin
            state_next = ATTACK;
            level_next = ENV_MIN;
            retrig     = 1'b1;
        end
`endif
    end

    assign product = sample_in * env_level;

    // NOTE: registers are written with non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            env_state  <= IDLE;
            env_level  <= ENV_MIN;
            sample_out <= 8'd0;
        end else begin
            env_state  <= state_next;
            env_level  <= level_next;
            sample_out <= product[15:8];
        end
    end

endmodule
